issue_ctrl: RTL and testbench
=============================

# issue_ctrl

Single-entry issue controller between `decoder` and the execute stage. It captures each decoded instruction and tracks pending destination registers in a 32-bit scoreboard. It holds the instruction until read-after-write (RAW), write-after-write (WAW) and structural hazards clear, then presents it to the ALU with a valid/ready handshake. It also owns the busy timer for the shared multi-cycle MUL/DIV unit.

## Interface
- `MUL_LAT`, default 3: cycles the MUL unit stays busy after issue of MUL/MULH/MULHSU/MULHU (≥1).
- `DIV_LAT`, default 16: cycles the DIV unit stays busy after issue of a divide op (≥1).
- `clk` in 1: single clock; all state updates on the posedge.
- `reset` in 1: asynchronous, active-low.
- `dec_valid` in 1: decoder presents an instruction.
- `dec_ready` out 1: controller accepts this cycle.
- `dec_rd`, `dec_rs1`, `dec_rs2` in 5 each: register fields from the decoder.
- `dec_imm` in 32: immediate.
- `dec_alu_op` in 11: ALU op code.
- `dec_type` in 4: `instr_type` code.
- `dec_reg_write` in 1: instruction writes `rd`.
- `iss_valid` out 1: instruction offered to execute.
- `iss_ready` in 1: execute accepts.
- `iss_rd`, `iss_rs1`, `iss_rs2`, `iss_imm`, `iss_alu_op`, `iss_type`, `iss_reg_write` out: held copies of the `dec_*` fields, same widths.
- `wb_valid` in 1: writeback completes.
- `wb_rd` in 5: register being written back; its pending bit clears.
- `flush` in 1: discard the held instruction.
- `lu_busy` out 1: long unit occupied.
- `stall_cnt` out 32: count of cycles with `hold_valid && !issue_fire`.

## Operation
- Holding FSM:
  - States: EMPTY (`hold_valid`=0) and HELD (`hold_valid`=1).
  - `dec_ready = !hold_valid || issue_fire`.
  - Accept (`dec_valid && dec_ready`) latches all `dec_*` into the hold register → HELD.
  - `issue_fire` without an accept → EMPTY.
  - `issue_fire` with an accept → stay HELD with the new contents.
- Source usage by `dec_type`:
  - RTYPE, SBTYPE, STYPE: read rs1 and rs2.
  - ITYPE: reads rs1 only.
  - UTYPE, UJTYPE, NOTYPE: read neither.
  - x0 is never considered pending.
- `hazard` is true when any of:
  - RAW: `pend[rs1]` or `pend[rs2]`, for sources the type uses.
  - WAW: `iss_reg_write && pend[rd]`.
  - Structural: the op is a long op and `lu_busy`.
- `iss_valid = hold_valid && !hazard && !flush`; `issue_fire = iss_valid && iss_ready`.
- Scoreboard update each cycle:
  - A write-back with `wb_valid` and `wb_rd`≠0 clears `pend[wb_rd]`.
  - `issue_fire` with `iss_reg_write` and `rd`≠0 sets `pend[rd]`.
  - If both hit the same index in the same cycle, set wins.
- Hazard checks use the registered scoreboard; there is no clear-to-issue bypass, so a dependent instruction issues at the earliest one cycle after the write-back edge.
- Long-unit timer:
  - States: LU_IDLE and LU_BUSY.
  - `issue_fire` of a MUL-class op loads the counter with `MUL_LAT`; a DIV-class op loads `DIV_LAT`; either moves to LU_BUSY.
  - In LU_BUSY the counter decrements each cycle; on reaching 0 → LU_IDLE.
  - `lu_busy` = LU_BUSY.
- Flush:
  - Clears `hold_valid` at the next edge and masks `iss_valid` in the same cycle.
  - Does not touch the scoreboard or the timer, because in-flight ops still write back.
  - `dec_ready` is forced to 0 while `flush` is high.
- `stall_cnt` wraps modulo 2^32.

## Timing
- Reset (async assert, sync release): all outputs and state are 0.
  - FSM goes to EMPTY and LU_IDLE; `pend` is cleared.
  - `dec_ready`=1 after reset (EMPTY); all other outputs are 0.
  - Reset asserted mid-operation drops the held instruction and clears all pending bits.
- Latency: an instruction accepted at edge N can have `iss_valid` high in cycle N+1 at the earliest.
- Throughput: 1 per cycle with no hazards and `iss_ready` held high.
- `iss_*` fields are stable while `iss_valid && !iss_ready`.
- The controller never withdraws `iss_valid` except on flush or reset.
- Long op issued at edge N: `lu_busy` is high for cycles N+1 … N+LAT.
  - A following long op can fire in cycle N+LAT+1 at the earliest.

## Structure
- Package `issue_pkg` holds:
  - state enums (`hold_state_t`, `lu_state_t`);
  - the type codes mirrored from `Sysbus.defs`;
  - the MUL-class and DIV-class op-code lists (`MUL`, `MULH`, `MULHSU`, `MULHU`; divide = 11'd4);
  - functions `uses_rs1`, `uses_rs2`, `is_mul`, `is_div`.
- Sub-module: `scoreboard` (32-bit pending vector, set/clear ports, two read ports plus one rd read port).

## Test plan
- Back-to-back independent: `add x1,x2,x3` then `add x4,x5,x6`, with `iss_ready`=1 and no write-back → issued on consecutive cycles; `pend` = bits 1 and 4.
- RAW: issue `add x5,…`, then `addi x6,x5,1` → `iss_valid` stays 0 until `wb_rd`=5 is seen; issues the next cycle; `stall_cnt` equals the stall cycles.
- Structural: `mul x1` then `div x2` with `MUL_LAT`=3 → div fires exactly 4 cycles after mul; `lu_busy` is high for 16 cycles after the div.
- Same-cycle event: `wb_rd`=7 in the same cycle as issue of a writer to x7 → `pend[7]`=1 afterwards.
- Backpressure and flush: hold `iss_ready`=0 for 5 cycles → `iss_*` stable and `dec_ready`=0; then `flush` → `iss_valid` drops that cycle and EMPTY at the next edge.
- Reset mid-stall: assert `reset`=0 while HELD with `pend`≠0 → all outputs 0 immediately; `dec_ready`=1 after release.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types, instruction-type codes and op-code classification for the issue controller.
package issue_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } hold_state_t;

    typedef enum logic {
        LU_IDLE = 1'b0,
        LU_BUSY = 1'b1
    } lu_state_t;

    // instr_type codes, kept in step with the decoder's definitions
    localparam logic [3:0] NOTYPE = 4'd0;
    localparam logic [3:0] RTYPE  = 4'd1;
    localparam logic [3:0] ITYPE  = 4'd2;
    localparam logic [3:0] STYPE  = 4'd3;
    localparam logic [3:0] SBTYPE = 4'd4;
    localparam logic [3:0] UTYPE  = 4'd5;
    localparam logic [3:0] UJTYPE = 4'd6;

    // Long-unit op codes
    localparam logic [10:0] MUL    = 11'd10;
    localparam logic [10:0] MULH   = 11'd11;
    localparam logic [10:0] MULHSU = 11'd12;
    localparam logic [10:0] MULHU  = 11'd13;
    localparam logic [10:0] DIV    = 11'd4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [10:0] alu_op;
        logic [3:0]  typ;
        logic        reg_write;
    } instr_t;

    function automatic logic uses_rs1(input logic [3:0] typ);
        return (typ == RTYPE) || (typ == SBTYPE) || (typ == STYPE) || (typ == ITYPE);
    endfunction

    function automatic logic uses_rs2(input logic [3:0] typ);
        return (typ == RTYPE) || (typ == SBTYPE) || (typ == STYPE);
    endfunction

    function automatic logic is_mul(input logic [10:0] op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == MULHU);
    endfunction

    function automatic logic is_div(input logic [10:0] op);
        return op == DIV;
    endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// 32-entry pending-destination scoreboard; x0 is never marked, set beats clear on the same index.
module scoreboard (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic [4:0] rs1_idx,
    input  logic [4:0] rs2_idx,
    input  logic [4:0] rd_idx,
    output logic       rs1_pend,
    output logic       rs2_pend,
    output logic       rd_pend
);

    logic [31:0] pend;
    logic [31:0] pend_nxt;

    always_comb begin
        pend_nxt = pend;
        if (clr_en && (clr_idx != 5'd0))
            pend_nxt[clr_idx] = 1'b0;
        if (set_en && (set_idx != 5'd0))
            pend_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pend <= '0;
        else
            pend <= pend_nxt;
    end

    assign rs1_pend = pend[rs1_idx];
    assign rs2_pend = pend[rs2_idx];
    assign rd_pend  = pend[rd_idx];

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue stage: holds one decoded instruction until RAW/WAW/structural hazards clear.
module issue_ctrl
    import issue_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [4:0]  dec_rd,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [31:0] dec_imm,
    input  logic [10:0] dec_alu_op,
    input  logic [3:0]  dec_type,
    input  logic        dec_reg_write,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [4:0]  iss_rd,
    output logic [4:0]  iss_rs1,
    output logic [4:0]  iss_rs2,
    output logic [31:0] iss_imm,
    output logic [10:0] iss_alu_op,
    output logic [3:0]  iss_type,
    output logic        iss_reg_write,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        lu_busy,
    output logic [31:0] stall_cnt
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(LAT_MAX + 1);

    hold_state_t hold_st, hold_nxt;
    lu_state_t   lu_st, lu_nxt;
    instr_t      hold;
    logic [CW-1:0] lu_cnt, lu_cnt_nxt;

    logic hold_valid;
    logic issue_fire;
    logic accept;
    logic hazard;
    logic long_op;
    logic rs1_pend, rs2_pend, rd_pend;

    scoreboard u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue_fire && hold.reg_write),
        .set_idx  (hold.rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_rd),
        .rs1_idx  (hold.rs1),
        .rs2_idx  (hold.rs2),
        .rd_idx   (hold.rd),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend)
    );

    // Hazards read the registered scoreboard only; no write-back bypass.
    always_comb begin
        long_op = is_mul(hold.alu_op) || is_div(hold.alu_op);
        hazard  = (uses_rs1(hold.typ) && rs1_pend)
               || (uses_rs2(hold.typ) && rs2_pend)
               || (hold.reg_write && rd_pend)
               || (long_op && lu_busy);
    end

    // ---------------- holding FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hold_st <= EMPTY;
        else
            hold_st <= hold_nxt;
    end

    always_comb begin
        hold_nxt = hold_st;
        case (hold_st)
            EMPTY: if (accept) hold_nxt = HELD;
            HELD: begin
                if (flush)
                    hold_nxt = EMPTY;
                else if (issue_fire && !accept)
                    hold_nxt = EMPTY;
            end
            default: hold_nxt = EMPTY;
        endcase
    end

    // dec_ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        hold_valid = (hold_st == HELD);
        iss_valid  = hold_valid && !hazard && !flush;
        issue_fire = iss_valid && iss_ready;
        dec_ready  = reset && !flush && (!hold_valid || issue_fire);
    end

    assign accept = dec_valid && dec_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hold <= '0;
        else if (accept)
            hold <= '{rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, imm: dec_imm,
                      alu_op: dec_alu_op, typ: dec_type, reg_write: dec_reg_write};
    end

    assign iss_rd        = hold.rd;
    assign iss_rs1       = hold.rs1;
    assign iss_rs2       = hold.rs2;
    assign iss_imm       = hold.imm;
    assign iss_alu_op    = hold.alu_op;
    assign iss_type      = hold.typ;
    assign iss_reg_write = hold.reg_write;

    // ---------------- long-unit timer ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lu_st  <= LU_IDLE;
            lu_cnt <= '0;
        end else begin
            lu_st  <= lu_nxt;
            lu_cnt <= lu_cnt_nxt;
        end
    end

    // Busy for exactly LAT cycles after the issuing edge: leave BUSY as the count hits 0.
    always_comb begin
        lu_nxt     = lu_st;
        lu_cnt_nxt = lu_cnt;
        case (lu_st)
            LU_IDLE: begin
                if (issue_fire && long_op) begin
                    lu_nxt     = LU_BUSY;
                    lu_cnt_nxt = is_div(hold.alu_op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                end
            end
            LU_BUSY: begin
                lu_cnt_nxt = lu_cnt - 1'b1;
                if (lu_cnt == CW'(1))
                    lu_nxt = LU_IDLE;
            end
            default: lu_nxt = LU_IDLE;
        endcase
    end

    always_comb begin
        lu_busy = (lu_st == LU_BUSY);
    end

    // ---------------- stall counter ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (hold_valid && !issue_fire)
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized and directed bench for issue_ctrl against a cycle-level behavioural model.
module tb_issue_ctrl;
    import issue_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        dec_valid, dec_ready;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] dec_imm;
    logic [10:0] dec_alu_op;
    logic [3:0]  dec_type;
    logic        dec_reg_write;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd, iss_rs1, iss_rs2;
    logic [31:0] iss_imm;
    logic [10:0] iss_alu_op;
    logic [3:0]  iss_type;
    logic        iss_reg_write;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        lu_busy;
    logic [31:0] stall_cnt;

    issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_imm(dec_imm), .dec_alu_op(dec_alu_op), .dec_type(dec_type),
        .dec_reg_write(dec_reg_write),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_imm(iss_imm), .iss_alu_op(iss_alu_op), .iss_type(iss_type),
        .iss_reg_write(iss_reg_write),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .lu_busy(lu_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit          m_held;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_imm;
    logic [10:0] m_op;
    logic [3:0]  m_type;
    bit          m_rw;
    bit          m_pend[32];
    int          m_lu_left;
    int          m_stall;
    int          cyc = 0;
    int          last_fire = -1;
    bit          obs_iv, obs_dr, obs_lu;
    logic [4:0]  obs_rd;

    function automatic bit reads1(input logic [3:0] t);
        return t inside {RTYPE, SBTYPE, STYPE, ITYPE};
    endfunction

    function automatic bit reads2(input logic [3:0] t);
        return t inside {RTYPE, SBTYPE, STYPE};
    endfunction

    function automatic int lat_of(input logic [10:0] op);
        if (op inside {MUL, MULH, MULHSU, MULHU}) return MUL_LAT;
        if (op == DIV) return DIV_LAT;
        return 0;
    endfunction

    task automatic model_clear();
        m_held = 0;
        m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_op = '0; m_type = '0; m_rw = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_lu_left = 0;
        m_stall = 0;
    endtask

    task automatic idle_in();
        dec_valid = 0; wb_valid = 0; wb_rd = '0; flush = 0; iss_ready = 1;
    endtask

    task automatic present(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [10:0] op, input logic [3:0] t, input bit rw);
        dec_valid = 1; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_alu_op = op; dec_type = t; dec_reg_write = rw; dec_imm = $urandom;
    endtask

    // One clock: check outputs at the negedge against the model, then advance the model at the posedge.
    task automatic step();
        bit e_haz, e_iv, e_dr, fire, acc;
        int lat;
        @(negedge clk);
        lat   = lat_of(m_op);
        e_haz = (reads1(m_type) && m_pend[m_rs1]) || (reads2(m_type) && m_pend[m_rs2])
             || (m_rw && m_pend[m_rd]) || (lat > 0 && m_lu_left > 0);
        e_iv  = m_held && !e_haz && !flush;
        e_dr  = !flush && (!m_held || (e_iv && iss_ready));
        chk("iss_valid", 32'(iss_valid), 32'(e_iv));
        chk("dec_ready", 32'(dec_ready), 32'(e_dr));
        chk("lu_busy", 32'(lu_busy), 32'(m_lu_left > 0));
        chk("stall_cnt", stall_cnt, 32'(m_stall));
        if (e_iv) begin
            chk("iss_rd", 32'(iss_rd), 32'(m_rd));
            chk("iss_rs1", 32'(iss_rs1), 32'(m_rs1));
            chk("iss_rs2", 32'(iss_rs2), 32'(m_rs2));
            chk("iss_imm", iss_imm, m_imm);
            chk("iss_alu_op", 32'(iss_alu_op), 32'(m_op));
            chk("iss_type", 32'(iss_type), 32'(m_type));
            chk("iss_reg_write", 32'(iss_reg_write), 32'(m_rw));
        end
        obs_iv = iss_valid; obs_dr = dec_ready; obs_lu = lu_busy; obs_rd = iss_rd;
        fire = e_iv && iss_ready;
        acc  = dec_valid && e_dr;
        @(posedge clk);
        cyc++;
        if (fire) last_fire = cyc;
        if (m_held && !fire) m_stall++;
        if (wb_valid && wb_rd != 0) m_pend[wb_rd] = 0;
        if (fire && m_rw && m_rd != 0) m_pend[m_rd] = 1;
        if (fire && lat > 0) m_lu_left = lat;
        else if (m_lu_left > 0) m_lu_left--;
        if (flush) m_held = 0;
        else if (acc) begin
            m_held = 1; m_rd = dec_rd; m_rs1 = dec_rs1; m_rs2 = dec_rs2;
            m_imm = dec_imm; m_op = dec_alu_op; m_type = dec_type; m_rw = dec_reg_write;
        end else if (fire) m_held = 0;
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 0;
        #2;
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_dec_ready", 32'(dec_ready), 32'd0);
        chk("rst_lu_busy", 32'(lu_busy), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_iss_rd", 32'(iss_rd), 32'd0);
        chk("rst_iss_imm", iss_imm, 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f1, mf, busy;
        idle_in();
        dec_rd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_imm = '0;
        dec_alu_op = '0; dec_type = '0; dec_reg_write = 0;
        #1;
        do_reset();
        step();
        chk("post_reset_dec_ready", 32'(obs_dr), 32'd1);

        // Back-to-back independent adds, then prove x1 and x4 are pending
        present(5'd1, 5'd2, 5'd3, 11'd0, RTYPE, 1); step();
        present(5'd4, 5'd5, 5'd6, 11'd0, RTYPE, 1); step();
        f1 = last_fire;
        idle_in(); step();
        chk("b2b_gap", 32'(last_fire - f1), 32'd1);
        present(5'd8, 5'd1, 5'd4, 11'd0, RTYPE, 0); step();
        idle_in(); step();
        chk("b2b_blocked", 32'(obs_iv), 32'd0);
        wb_valid = 1; wb_rd = 5'd1; step();
        wb_rd = 5'd4; step();
        chk("b2b_x4_still_pend", 32'(obs_iv), 32'd0);
        wb_valid = 0; step();
        chk("b2b_release", 32'(obs_iv), 32'd1);

        // RAW stall on x5 until write-back, issue one cycle after
        do_reset();
        present(5'd5, 5'd1, 5'd2, 11'd0, RTYPE, 1); step();
        present(5'd6, 5'd5, 5'd0, 11'd0, ITYPE, 1); step();
        idle_in(); repeat (4) step();
        wb_valid = 1; wb_rd = 5'd5; step();
        chk("raw_hold_at_wb", 32'(obs_iv), 32'd0);
        wb_valid = 0; step();
        chk("raw_issue", 32'(obs_iv), 32'd1);
        chk("raw_rd", 32'(obs_rd), 32'd6);
        chk("raw_stall_cnt", stall_cnt, 32'd5);

        // Structural: mul then div
        do_reset();
        present(5'd1, 5'd2, 5'd3, MUL, RTYPE, 1); step();
        present(5'd2, 5'd4, 5'd5, DIV, RTYPE, 1); step();
        mf = last_fire;
        idle_in();
        for (int i = 0; i < 40 && last_fire == mf; i++) step();
        chk("struct_gap", 32'(last_fire - mf), 32'(MUL_LAT + 1));
        busy = 0;
        repeat (DIV_LAT + 4) begin step(); if (obs_lu) busy++; end
        chk("div_busy_cycles", 32'(busy), 32'(DIV_LAT));

        // Write-back and issue to x7 on the same edge: set wins
        do_reset();
        present(5'd7, 5'd1, 5'd2, 11'd0, RTYPE, 1); step();
        idle_in(); wb_valid = 1; wb_rd = 5'd7; step();
        wb_valid = 0; present(5'd9, 5'd7, 5'd0, 11'd0, RTYPE, 0); step();
        idle_in(); step();
        chk("samecyc_pend7", 32'(obs_iv), 32'd0);
        wb_valid = 1; wb_rd = 5'd7; step();
        wb_valid = 0; step();
        chk("samecyc_release", 32'(obs_iv), 32'd1);

        // Backpressure then flush
        do_reset();
        present(5'd3, 5'd1, 5'd2, 11'd0, RTYPE, 1); step();
        present(5'd10, 5'd11, 5'd12, 11'd0, RTYPE, 1); iss_ready = 0;
        repeat (5) begin
            step();
            chk("bp_iss_rd", 32'(obs_rd), 32'd3);
            chk("bp_dec_ready", 32'(obs_dr), 32'd0);
        end
        flush = 1; step();
        chk("flush_mask", 32'(obs_iv), 32'd0);
        idle_in(); step();
        chk("flush_empty_iv", 32'(obs_iv), 32'd0);
        chk("flush_empty_dr", 32'(obs_dr), 32'd1);

        // Reset in the middle of a RAW stall
        do_reset();
        present(5'd5, 5'd1, 5'd2, 11'd0, RTYPE, 1); step();
        present(5'd6, 5'd5, 5'd0, 11'd0, ITYPE, 1); step();
        idle_in(); step(); step();
        do_reset();
        step();
        chk("post_rst_dr", 32'(obs_dr), 32'd1);
        present(5'd6, 5'd5, 5'd0, 11'd0, ITYPE, 1); step();
        idle_in(); step();
        chk("post_rst_pend_clear", 32'(obs_iv), 32'd1);

        // Randomized traffic over a small register window to provoke hazards
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            dec_valid = ($urandom_range(0, 3) != 0);
            dec_rd = 5'($urandom_range(0, 7));
            dec_rs1 = 5'($urandom_range(0, 7));
            dec_rs2 = 5'($urandom_range(0, 7));
            dec_imm = $urandom;
            dec_type = 4'($urandom_range(0, 6));
            case ($urandom_range(0, 9))
                0: dec_alu_op = MUL;
                1: dec_alu_op = MULHU;
                2: dec_alu_op = DIV;
                default: dec_alu_op = 11'($urandom_range(0, 31));
            endcase
            dec_reg_write = ($urandom_range(0, 3) != 0);
            iss_ready = ($urandom_range(0, 3) != 0);
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_rd = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
